alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 8, data-path and bus width in bits.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 op  input  alu_op_t  operation select, sampled every cycle.
REQ-005 bus  inout  WIDTH  shared tri-state data bus; ALU drives it only on read/compute ops, otherwise high-Z.

Function
REQ-006 Internal state SHALL be two WIDTH-bit registers R0 and R1; no other state.
REQ-007 ALU_NOP: no register update; bus not driven (Z).
REQ-008 ALU_WRITE_R0: at rising clock edge R0 <= bus; bus not driven by ALU.
REQ-009 ALU_WRITE_R1: at rising clock edge R1 <= bus; bus not driven by ALU.
REQ-010 ALU_READ_R0 / ALU_READ_R1: ALU drives R0 / R1 onto bus combinationally while op is held; no register update.
REQ-011 ALU_ADD: ALU drives (R0 + R1) mod 2^WIDTH onto bus; carry discarded.
REQ-012 ALU_SUB: ALU drives (R0 - R1) mod 2^WIDTH onto bus; borrow discarded, e.g. 3-5 -> 254.
REQ-013 ALU_INC: ALU drives (R1 + 1) mod 2^WIDTH onto bus; R0 ignored; 255 -> 0.
REQ-014 Results of ADD/SUB/INC SHALL NOT be written back to R0 or R1; registers change only on WRITE ops.
REQ-015 Drive timing: bus value SHALL be valid within the same cycle op is applied; zero-cycle latency from op/registers to bus; a write followed next cycle by a read returns the new value.
REQ-016 Bus returns to Z in the first cycle op leaves a read/compute op, with no cycle of stale drive.
REQ-017 The ALU SHALL never drive bus during a WRITE op, so an external driver has sole ownership.

Reset
REQ-018 While reset=1, at each rising edge R0 and R1 <= 0; WRITE ops are ignored.
REQ-019 While reset=1, the ALU SHALL NOT drive bus regardless of op, so external drivers may use it.
REQ-020 Reset SHALL take priority over any op in the same cycle; the first op after deassertion executes normally.

Structure
REQ-021 Shared package alu_pkg SHALL hold typedef enum logic[2:0] alu_op_t: ALU_NOP=0, ALU_WRITE_R0=1, ALU_WRITE_R1=2, ALU_READ_R0=3, ALU_READ_R1=4, ALU_ADD=5, ALU_SUB=6, ALU_INC=7.
REQ-022 Sub-module tri_buf (parameter WIDTH=8; ports rw in 1, data in WIDTH, bus inout WIDTH) SHALL drive data onto bus when rw=1, else Z; ALU SHALL drive bus only through one tri_buf instance.
REQ-023 Result mux and drive-enable decode SHALL be combinational from op, R0, R1, and reset.

Verification
REQ-024 Bus idle: reset=1, op=NOP, external drive 10 -> bus=10; external release -> bus=Z.
REQ-025 Add: WRITE_R0 10'd1, WRITE_R1 5, ADD -> bus=6; 200+100 -> 44.
REQ-026 Sub: WRITE_R0 5, WRITE_R1 3, SUB -> bus=2; R0=3, R1=5 -> 254.
REQ-027 Inc: WRITE_R1 1, INC -> 2; WRITE_R1 255, INC -> 0.
REQ-028 Read-back: WRITE_R0 15, READ_R0 -> 15; WRITE_R1 15, READ_R1 -> 15; next NOP -> Z.
REQ-029 Reset: load R0=7, R1=9, assert reset one cycle, READ_R0 and READ_R1 -> 0 each.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding for the bus ALU and a helper that classifies
// which opcodes place a value on the shared bus.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_NOP      = 3'd0,
    ALU_WRITE_R0 = 3'd1,
    ALU_WRITE_R1 = 3'd2,
    ALU_READ_R0  = 3'd3,
    ALU_READ_R1  = 3'd4,
    ALU_ADD      = 3'd5,
    ALU_SUB      = 3'd6,
    ALU_INC      = 3'd7
  } alu_op_t;

  // Read and compute ops are the only ones where the ALU owns the bus.
  function automatic logic op_drives_bus(input alu_op_t op);
    case (op)
      ALU_READ_R0, ALU_READ_R1, ALU_ADD, ALU_SUB, ALU_INC: op_drives_bus = 1'b1;
      default:                                             op_drives_bus = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_tri_buf.sv
// Tri-state bus driver: places data on the bus while rw is high, otherwise
// releases the bus to high impedance.
module tri_buf #(
  parameter int WIDTH = 8
) (
  input  logic             rw,
  input  logic [WIDTH-1:0] data,
  inout  wire  [WIDTH-1:0] bus
);

  assign bus = rw ? data : {WIDTH{1'bz}};

endmodule

// File: rtl/alu.sv
// Two-register ALU on a shared tri-state bus. Registers load only on WRITE
// ops; read and compute results are driven combinationally with no latency.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  alu_op_t          op,
  inout  wire  [WIDTH-1:0] bus
);

  logic [WIDTH-1:0] r0_q, r0_d;
  logic [WIDTH-1:0] r1_q, r1_d;
  logic [WIDTH-1:0] result;
  logic             drive_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      r0_q <= '0;
      r1_q <= '0;
    end else begin
      r0_q <= r0_d;
      r1_q <= r1_d;
    end
  end

  always_comb begin
    r0_d = r0_q;
    r1_d = r1_q;
    case (op)
      ALU_WRITE_R0: r0_d = bus;
      ALU_WRITE_R1: r1_d = bus;
      default: ;
    endcase
  end

  // Arithmetic wraps at WIDTH bits; carry and borrow are intentionally dropped.
  always_comb begin
    result = '0;
    case (op)
      ALU_READ_R0: result = r0_q;
      ALU_READ_R1: result = r1_q;
      ALU_ADD:     result = r0_q + r1_q;
      ALU_SUB:     result = r0_q - r1_q;
      ALU_INC:     result = r1_q + {{(WIDTH-1){1'b0}}, 1'b1};
      default:     result = '0;
    endcase
  end

  assign drive_en = !reset && op_drives_bus(op);

  tri_buf #(
    .WIDTH (WIDTH)
  ) u_tri_buf (
    .rw   (drive_en),
    .data (result),
    .bus  (bus)
  );

endmodule

// File: tb/tb_alu.sv
// Directed bench for the bus ALU. The bus is weakly pulled high, so a
// released (undriven) bus reads as all ones.
module tb_alu;
  import alu_pkg::*;

  localparam int WIDTH = 8;
  localparam logic [WIDTH-1:0] IDLE = 8'hFF;

  logic             clock;
  logic             reset;
  alu_op_t          op_s;
  logic             ext_en;
  logic [WIDTH-1:0] ext_val;
  tri1  [WIDTH-1:0] bus;

  int total = 0;
  int bad   = 0;

  assign bus = ext_en ? ext_val : {WIDTH{1'bz}};

  alu #(
    .WIDTH (WIDTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .op    (op_s),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0d", tag, got);
    end
  endtask

  // Inputs change on the falling edge; bus is sampled 2 time units later,
  // well before the next rising edge commits any write.
  task automatic apply(input logic rst, input alu_op_t op,
                       input logic en, input logic [WIDTH-1:0] val);
    @(negedge clock);
    reset   = rst;
    op_s    = op;
    ext_en  = en;
    ext_val = val;
    #2;
  endtask

  task automatic wr(input alu_op_t op, input logic [WIDTH-1:0] val);
    apply(1'b0, op, 1'b1, val);
  endtask

  task automatic run(input alu_op_t op);
    apply(1'b0, op, 1'b0, '0);
  endtask

  initial begin
    reset   = 1'b1;
    op_s    = ALU_NOP;
    ext_en  = 1'b1;
    ext_val = 8'd10;
    #2;
    check("idle_ext_drive", bus, 8'd10);
    ext_en = 1'b0;
    #1;
    check("idle_release", bus, IDLE);

    apply(1'b1, ALU_ADD, 1'b0, '0);
    check("reset_blocks_drive", bus, IDLE);
    apply(1'b1, ALU_READ_R0, 1'b0, '0);
    check("reset_blocks_read", bus, IDLE);

    wr(ALU_WRITE_R0, 8'd1);
    check("write_bus_owned", bus, 8'd1);
    wr(ALU_WRITE_R1, 8'd5);
    run(ALU_ADD);
    check("add_1_5", bus, 8'd6);
    run(ALU_READ_R0);
    check("add_no_writeback", bus, 8'd1);

    wr(ALU_WRITE_R0, 8'd200);
    wr(ALU_WRITE_R1, 8'd100);
    run(ALU_ADD);
    check("add_wrap", bus, 8'd44);

    wr(ALU_WRITE_R0, 8'd5);
    wr(ALU_WRITE_R1, 8'd3);
    run(ALU_SUB);
    check("sub_5_3", bus, 8'd2);
    wr(ALU_WRITE_R0, 8'd3);
    wr(ALU_WRITE_R1, 8'd5);
    run(ALU_SUB);
    check("sub_wrap", bus, 8'd254);

    wr(ALU_WRITE_R1, 8'd1);
    run(ALU_INC);
    check("inc_1", bus, 8'd2);
    wr(ALU_WRITE_R1, 8'd255);
    run(ALU_INC);
    check("inc_wrap", bus, 8'd0);
    run(ALU_READ_R1);
    check("inc_no_writeback", bus, 8'd255);

    wr(ALU_WRITE_R0, 8'd15);
    run(ALU_READ_R0);
    check("readback_r0", bus, 8'd15);
    wr(ALU_WRITE_R1, 8'd15);
    run(ALU_READ_R1);
    check("readback_r1", bus, 8'd15);
    run(ALU_NOP);
    check("nop_release", bus, IDLE);

    wr(ALU_WRITE_R0, 8'd7);
    wr(ALU_WRITE_R1, 8'd9);
    run(ALU_SUB);
    check("pre_reset_sub", bus, 8'd254);
    apply(1'b1, ALU_WRITE_R0, 1'b1, 8'h55);
    check("reset_ext_owns_bus", bus, 8'h55);
    run(ALU_READ_R0);
    check("reset_r0", bus, 8'd0);
    run(ALU_READ_R1);
    check("reset_r1", bus, 8'd0);
    run(ALU_INC);
    check("post_reset_inc", bus, 8'd1);
    run(ALU_NOP);
    check("final_release", bus, IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
